// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with a fixed clocks-per-bit divisor and a two-flop RX synchronizer.
// Define UART_LOOPBACK_EN to add a loopback input that routes the TX line into the RX path.
module uart_transceiver #(
  parameter int CLOCKS_PER_BIT = 86
) (
  input  logic       clock,
  input  logic       reset,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       tx_has_data,
  input  logic [7:0] tx_data_to_send,
  output logic       tx_sending_bit,
  output logic       tx_is_transmitting,
  output logic       tx_transmission_done,
  input  logic       rx_incoming_bit,
  output logic       rx_has_data,
  output logic [7:0] rx_data_received
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLOCKS_PER_BIT - 1) / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } txState_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rxState_e;

  txState_e      txState_q, txState_d;
  logic [CW-1:0] txCnt_q, txCnt_d;
  logic [2:0]    txBit_q, txBit_d;
  logic [7:0]    txShift_q, txShift_d;

  rxState_e      rxState_q, rxState_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]    rxBit_q, rxBit_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          rxValid_q, rxValid_d;
  logic          rxMeta_q, rxSync_q;
  logic          rxPin;

  always_ff @(posedge clock) begin
    if (reset) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
    end
  end

  // The TX line and status flags decode straight from the state so a reset edge releases the line at once.
  always_comb begin
    txState_d            = txState_q;
    txCnt_d              = txCnt_q;
    txBit_d              = txBit_q;
    txShift_d            = txShift_q;
    tx_sending_bit       = 1'b1;
    tx_is_transmitting   = 1'b0;
    tx_transmission_done = 1'b0;
    unique case (txState_q)
      TX_IDLE: begin
        if (tx_has_data) begin
          txShift_d = tx_data_to_send;
          txCnt_d   = '0;
          txBit_d   = '0;
          txState_d = TX_START;
        end
      end
      TX_START: begin
        tx_sending_bit     = 1'b0;
        tx_is_transmitting = 1'b1;
        if (txCnt_q == BIT_LAST) begin
          txCnt_d   = '0;
          txState_d = TX_DATA;
        end else begin
          txCnt_d = txCnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        tx_sending_bit     = txShift_q[txBit_q];
        tx_is_transmitting = 1'b1;
        if (txCnt_q == BIT_LAST) begin
          txCnt_d = '0;
          if (txBit_q == 3'd7) begin
            txState_d = TX_STOP;
          end else begin
            txBit_d = txBit_q + 3'd1;
          end
        end else begin
          txCnt_d = txCnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        tx_is_transmitting = 1'b1;
        if (txCnt_q == BIT_LAST) begin
          txCnt_d   = '0;
          txState_d = TX_DONE;
        end else begin
          txCnt_d = txCnt_q + CW'(1);
        end
      end
      TX_DONE: begin
        tx_transmission_done = 1'b1;
        txState_d            = TX_IDLE;
      end
      default: begin
        txState_d = TX_IDLE;
      end
    endcase
  end

`ifdef UART_LOOPBACK_EN
  assign rxPin = loopback ? tx_sending_bit : rx_incoming_bit;
`else
  assign rxPin = rx_incoming_bit;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
    end else begin
      rxMeta_q  <= rxPin;
      rxSync_q  <= rxMeta_q;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
    end
  end

  // The start bit is re-checked near its middle, which centres every later sample in its bit.
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;
    unique case (rxState_q)
      RX_IDLE: begin
        if (!rxSync_q) begin
          rxCnt_d   = '0;
          rxState_d = RX_START;
        end
      end
      RX_START: begin
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d = '0;
          if (!rxSync_q) begin
            rxBit_d   = '0;
            rxState_d = RX_DATA;
          end else begin
            rxState_d = RX_IDLE;
          end
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d            = '0;
          rxShift_d[rxBit_q] = rxSync_q;
          if (rxBit_q == 3'd7) begin
            rxState_d = RX_STOP;
          end else begin
            rxBit_d = rxBit_q + 3'd1;
          end
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d = '0;
          if (rxSync_q) begin
            rxData_d  = rxShift_q;
            rxValid_d = 1'b1;
            rxState_d = RX_IDLE;
          end else begin
            rxState_d = RX_RECOVER;
          end
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      RX_RECOVER: begin
        if (rxSync_q) begin
          rxState_d = RX_IDLE;
        end
      end
      default: begin
        rxState_d = RX_IDLE;
      end
    endcase
  end

  assign rx_has_data      = rxValid_q;
  assign rx_data_received = rxData_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: directed and randomized frames checked against
// a frame-level model of the 8N1 line format and a queue of received bytes.
module tb_uart_transceiver;

  localparam int CPB = 86;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       txHasData = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       rxDrive = 1'b1;
  logic       tieTx = 1'b0;
  logic       txLine, txBusy, txDone;
  logic       rxLine;
  logic       rxHasData;
  logic [7:0] rxDataReceived;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rxGot[$];
  int         doneCount = 0;
  logic       pulseWide = 1'b0;
  logic       rxPrev = 1'b0;

  assign rxLine = tieTx ? txLine : rxDrive;

  always #5 clock = ~clock;

  uart_transceiver #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock               (clock),
    .reset               (reset),
`ifdef UART_LOOPBACK_EN
    .loopback            (1'b0),
`endif
    .tx_has_data         (txHasData),
    .tx_data_to_send     (txData),
    .tx_sending_bit      (txLine),
    .tx_is_transmitting  (txBusy),
    .tx_transmission_done(txDone),
    .rx_incoming_bit     (rxLine),
    .rx_has_data         (rxHasData),
    .rx_data_received    (rxDataReceived)
  );

  // Collect every received byte and flag any rx_has_data pulse wider than one cycle.
  always @(negedge clock) begin
    if (rxHasData) rxGot.push_back(rxDataReceived);
    if (rxHasData && rxPrev) pulseWide = 1'b1;
    rxPrev = rxHasData;
    if (txDone) doneCount++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitRx(input int n);
    for (int k = 0; k < 2000 && rxGot.size() < n; k++) tick();
  endtask

  function automatic logic [7:0] gotByte(input int idx);
    return (rxGot.size() > idx) ? rxGot[idx] : 8'hEE;
  endfunction

  // Transmit one byte with RX tied to TX; check every line cycle against the 10-bit frame model.
  task automatic applyStimulus(input logic [7:0] b);
    logic [9:0] frame;
    int lineErr;
    int busyErr;
    frame   = {1'b1, b, 1'b0};
    lineErr = 0;
    busyErr = 0;
    rxGot.delete();
    txHasData = 1'b1;
    txData    = b;
    tick();
    txHasData = 1'b0;
    txData    = ~b;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (txLine !== frame[i / CPB]) lineErr++;
      if (txBusy !== 1'b1) busyErr++;
      tick();
    end
    checkOutput("txLineBits", lineErr, 0);
    checkOutput("txBusyWidth", busyErr, 0);
    checkOutput("txDonePulse", txDone, 1);
    checkOutput("txBusyAtDone", txBusy, 0);
    checkOutput("txLineAtDone", txLine, 1);
    tick();
    checkOutput("txDoneCleared", txDone, 0);
    waitRx(1);
    checkOutput("rxPulseCount", rxGot.size(), 1);
    checkOutput("rxByte", gotByte(0), b);
    checkOutput("rxHeld", rxDataReceived, b);
  endtask

  task automatic driveRxFrame(input logic [7:0] b, input logic stopBit);
    for (int i = 0; i < 10; i++) begin
      rxDrive = (i == 0) ? 1'b0 : (i == 9) ? stopBit : b[i-1];
      repeat (CPB) tick();
    end
    rxDrive = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic       stopBit;
    logic [7:0] lastGood;
    int         gap;
    int         baseDone;

    reset = 1'b1;
    repeat (3) tick();
    checkOutput("rstTxLine", txLine, 1);
    checkOutput("rstTxBusy", txBusy, 0);
    checkOutput("rstTxDone", txDone, 0);
    checkOutput("rstRxValid", rxHasData, 0);
    checkOutput("rstRxData", rxDataReceived, 8'h00);
    reset = 1'b0;
    tick();

    $display("[TB] line format and round trip 0xAB");
    tieTx = 1'b1;
    applyStimulus(8'hAB);

    $display("[TB] back-to-back 0x00 then 0xFF");
    rxGot.delete();
    txHasData = 1'b1;
    txData    = 8'h00;
    tick();
    txData = 8'hFF;
    for (int k = 0; k < 1000 && !txDone; k++) tick();
    checkOutput("b2bFirstDone", txDone, 1);
    gap = 0;
    while (!txBusy && gap < 10) begin
      gap++;
      tick();
    end
    checkOutput("b2bGap", gap, 2);
    txHasData = 1'b0;
    for (int k = 0; k < 1000 && !txDone; k++) tick();
    checkOutput("b2bSecondDone", txDone, 1);
    tick();
    waitRx(2);
    checkOutput("b2bRxCount", rxGot.size(), 2);
    checkOutput("b2bRxFirst", gotByte(0), 8'h00);
    checkOutput("b2bRxSecond", gotByte(1), 8'hFF);

    $display("[TB] glitch rejection");
    tieTx   = 1'b0;
    rxDrive = 1'b1;
    repeat (10) tick();
    rxGot.delete();
    rxDrive = 1'b0;
    repeat (20) tick();
    rxDrive = 1'b1;
    repeat (300) tick();
    checkOutput("glitchNoPulse", rxGot.size(), 0);
    checkOutput("glitchHold", rxDataReceived, 8'hFF);
    driveRxFrame(8'h5A, 1'b1);
    repeat (50) tick();
    checkOutput("glitchNextCount", rxGot.size(), 1);
    checkOutput("glitchNextByte", rxDataReceived, 8'h5A);

    $display("[TB] framing error");
    rxGot.delete();
    driveRxFrame(8'h3C, 1'b0);
    repeat (100) tick();
    checkOutput("frameErrNoPulse", rxGot.size(), 0);
    checkOutput("frameErrHold", rxDataReceived, 8'h5A);
    driveRxFrame(8'hC3, 1'b1);
    repeat (50) tick();
    checkOutput("frameRecoverCount", rxGot.size(), 1);
    checkOutput("frameRecoverByte", rxDataReceived, 8'hC3);

    $display("[TB] randomized RX frames");
    lastGood = 8'hC3;
    for (int r = 0; r < 6; r++) begin
      b       = 8'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 3) != 0);
      rxGot.delete();
      driveRxFrame(b, stopBit);
      repeat (60 + $urandom_range(0, 40)) tick();
      if (stopBit) lastGood = b;
      checkOutput("rndRxCount", rxGot.size(), stopBit ? 1 : 0);
      checkOutput("rndRxData", rxDataReceived, lastGood);
    end

    $display("[TB] randomized TX round trips");
    tieTx = 1'b1;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 20)) tick();
    end

    $display("[TB] reset during TX data bit 3");
    rxGot.delete();
    baseDone  = doneCount;
    txHasData = 1'b1;
    txData    = 8'h96;
    tick();
    txHasData = 1'b0;
    repeat (CPB * 4 + 20) tick();
    checkOutput("midFrameBusy", txBusy, 1);
    reset = 1'b1;
    tick();
    checkOutput("midRstLine", txLine, 1);
    checkOutput("midRstBusy", txBusy, 0);
    checkOutput("midRstDone", txDone, 0);
    checkOutput("midRstRxData", rxDataReceived, 8'h00);
    reset = 1'b0;
    repeat (1200) tick();
    checkOutput("midRstNoDone", doneCount - baseDone, 0);
    checkOutput("midRstNoRx", rxGot.size(), 0);
    applyStimulus(8'h81);

    checkOutput("rxPulseOneCycle", pulseWide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
